except_encoder: RTL and testbench
=================================

# except_encoder

MEM-stage exception collector and the producer side of the 14-bit `excepttype` bus consumed by CP0. It registers per-instruction exception and CP0-access flags from EX, tracks branch delay slots, and resolves simultaneous exceptions to a single one-hot cause. It presents the packed bus with the matching PC and rt data every cycle, and squashes itself when CP0 raises `to_be_flushed`.

## Interface
- `PC_RESET`, 32'hbfc00000, reset value of `current_pc`
- `clk`  input  1  system clock
- `rst`  input  1  synchronous active-high reset, sampled on `clk` rising edge
- `stall`  input  1  MEM stage hold; register keeps its contents
- `flush`  input  1  CP0 `to_be_flushed`; squashes the stage
- `ex_valid`  input  1  EX holds a real instruction (0 = bubble)
- `ex_pc`  input  32  PC of the EX instruction
- `ex_is_branch`  input  1  instruction is a branch or jump (owns a delay slot)
- `ex_addr_err`, `ex_overflow`, `ex_syscall`, `ex_break`, `ex_invalid`  input  1 each  raw exception flags
- `ex_eret`, `ex_mfc0`, `ex_mtc0`  input  1 each  CP0 instruction flags
- `ex_cp0_addr`  input  5  CP0 register number ({rd[4:0]})
- `ex_rt_rdata`  input  32  rt operand for mtc0
- `excepttype`  output  14  {target_addr[13:9], in_delayslot[8], addr[7], overflow[6], syscall[5], break[4], invalid[3], eret[2], mfc0[1], mtc0[0]}
- `current_pc`  output  32  PC of the MEM instruction
- `rt_rdata`  output  32  registered rt operand
- `mem_valid`  output  1  MEM holds a real instruction

## Operation
- Stage register loads on every rising edge unless `stall`=1. Priority per edge: `rst` > `flush` > `stall` > load.
- Reset: `excepttype`=0, `current_pc`=`PC_RESET`, `rt_rdata`=0, `mem_valid`=0, delay-slot tracker cleared.
- Flush: `mem_valid`=0, `excepttype`=0, tracker cleared. `current_pc` and `rt_rdata` keep their values. Flush is honoured even when `stall`=1.
- Bubble load (`ex_valid`=0): `mem_valid`=0, `excepttype`=0, `current_pc` follows `ex_pc`. The tracker is not consumed.
- Exception priority, one-hot: addr > invalid > syscall > break > overflow. Only the winning bit is set in [7:3].
- If any exception bit is set, bits [2:0] and [13:9] are forced to 0. An exception masks eret, mfc0 and mtc0.
- With no exception, [2:0] copy the eret/mfc0/mtc0 flags. [13:9] = `ex_cp0_addr` only if mfc0 or mtc0 is set, else 0.
- Delay-slot tracker is a single state bit, `ds_pending`: IDLE (0) or PENDING (1).
  - IDLE -> PENDING on an accepted valid load with `ex_is_branch`=1.
  - PENDING -> IDLE on the next accepted valid load. That instruction gets bit [8]=1. If it is itself a branch, the tracker re-enters PENDING.
  - Bubbles and stalled cycles leave the state unchanged.
  - Flush or reset forces IDLE.
- Bit [8] is set for every valid delay-slot instruction, exception or not. CP0 subtracts 4 from `current_pc` for EPC.
- `rt_rdata` is loaded with `ex_rt_rdata` on every accepted load.

## Timing
- One cycle of latency from EX inputs to outputs. All outputs come from registers; there is no combinational input-to-output path.
- `flush` arrives in the same cycle the faulting or eret instruction sits in MEM. On the next edge the stage is squashed, and the instruction loaded that edge never appears.
- Reset asserted mid-stall or mid-PENDING returns everything to reset values on that edge.
- Stalled: outputs are held bit-exact for any stall length, with the tracker frozen.

## Test plan
- Reset: assert `rst` for 2 cycles with random EX inputs -> `excepttype`=14'h0, `current_pc`=32'hbfc00000, `mem_valid`=0.
- Priority: `ex_valid`=1 with addr_err, overflow, syscall and eret all =1 -> next cycle `excepttype`=14'h0080. Overflow alone -> 14'h0040.
- mfc0: `ex_mfc0`=1, `ex_cp0_addr`=5'd12 -> `excepttype`=14'h1802. The same with syscall=1 -> 14'h0020.
- Delay slot: branch at 0x100, bubble, syscall at 0x104 -> the syscall cycle shows `excepttype`=14'h0120 and `current_pc`=0x104. The following instruction has bit [8]=0.
- Flush: tracker PENDING, assert `flush` together with `stall`=1 -> next cycle `mem_valid`=0 and `excepttype`=0. The next valid instruction has bit [8]=0.
- Stall hold: load mtc0 (addr 5'd14, rt=32'hdeadbeef), then stall 3 cycles while EX changes -> outputs stay 14'h1C01 / 32'hdeadbeef throughout.

Source files
------------

// File: rtl/except_encoder.sv
// rtl/except_encoder.sv - MEM-stage exception collector producing the one-hot excepttype bus for CP0
module except_encoder #(
  parameter logic [31:0] PC_RESET = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_addr_err,
  input  logic        ex_overflow,
  input  logic        ex_syscall,
  input  logic        ex_break,
  input  logic        ex_invalid,
  input  logic        ex_eret,
  input  logic        ex_mfc0,
  input  logic        ex_mtc0,
  input  logic [4:0]  ex_cp0_addr,
  input  logic [31:0] ex_rt_rdata,
  output logic [13:0] excepttype,
  output logic [31:0] current_pc,
  output logic [31:0] rt_rdata,
  output logic        mem_valid
);

  typedef enum logic {
    DS_IDLE    = 1'b0,
    DS_PENDING = 1'b1
  } ds_state_t;

  ds_state_t   ds_pending;
  ds_state_t   ds_next;
  logic        has_exc;
  logic [4:0]  cause;
  logic [13:0] excepttype_next;

  // Delay-slot tracker state register; reset and flush both drop a pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ds_pending <= DS_IDLE;
    end else begin
      ds_pending <= ds_next;
    end
  end

  // Tracker next state: only accepted valid loads move it, and a branch re-arms it.
  always_comb begin
    ds_next = ds_pending;
    if (flush) begin
      ds_next = DS_IDLE;
    end else if (!stall && ex_valid) begin
      ds_next = ex_is_branch ? DS_PENDING : DS_IDLE;
    end
  end

  // Resolve simultaneous exceptions to one cause: addr > invalid > syscall > break > overflow.
  // cause is ordered {addr, overflow, syscall, break, invalid} to land directly on bits [7:3].
  always_comb begin
    cause   = 5'b00000;
    has_exc = ex_addr_err | ex_overflow | ex_syscall | ex_break | ex_invalid;
    if (ex_addr_err) begin
      cause = 5'b10000;
    end else if (ex_invalid) begin
      cause = 5'b00001;
    end else if (ex_syscall) begin
      cause = 5'b00100;
    end else if (ex_break) begin
      cause = 5'b00010;
    end else if (ex_overflow) begin
      cause = 5'b01000;
    end
  end

  // Pack the bus; an exception masks the CP0 access fields, bubbles carry nothing.
  always_comb begin
    excepttype_next = 14'h0000;
    if (ex_valid) begin
      excepttype_next[8]   = (ds_pending == DS_PENDING);
      excepttype_next[7:3] = cause;
      if (!has_exc) begin
        excepttype_next[2:0] = {ex_eret, ex_mfc0, ex_mtc0};
        if (ex_mfc0 || ex_mtc0) begin
          excepttype_next[13:9] = ex_cp0_addr;
        end
      end
    end
  end

  // Stage register: rst > flush > stall > load; flush keeps PC and rt for CP0's use.
  always_ff @(posedge clk) begin
    if (rst) begin
      excepttype <= 14'h0000;
      current_pc <= PC_RESET;
      rt_rdata   <= 32'h0000_0000;
      mem_valid  <= 1'b0;
    end else if (flush) begin
      excepttype <= 14'h0000;
      mem_valid  <= 1'b0;
    end else if (!stall) begin
      excepttype <= excepttype_next;
      current_pc <= ex_pc;
      rt_rdata   <= ex_rt_rdata;
      mem_valid  <= ex_valid;
    end
  end

endmodule

// File: tb/tb_except_encoder.sv
// tb/tb_except_encoder.sv - table-driven scoreboard bench for except_encoder
module tb_except_encoder;

  localparam logic [31:0] PCR = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ex_valid, ex_is_branch;
  logic [31:0] ex_pc, ex_rt_rdata;
  logic        ex_addr_err, ex_overflow, ex_syscall, ex_break, ex_invalid;
  logic        ex_eret, ex_mfc0, ex_mtc0;
  logic [4:0]  ex_cp0_addr;
  logic [13:0] excepttype;
  logic [31:0] current_pc, rt_rdata;
  logic        mem_valid;

  except_encoder #(.PC_RESET(PCR)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_addr_err(ex_addr_err), .ex_overflow(ex_overflow), .ex_syscall(ex_syscall),
    .ex_break(ex_break), .ex_invalid(ex_invalid),
    .ex_eret(ex_eret), .ex_mfc0(ex_mfc0), .ex_mtc0(ex_mtc0),
    .ex_cp0_addr(ex_cp0_addr), .ex_rt_rdata(ex_rt_rdata),
    .excepttype(excepttype), .current_pc(current_pc), .rt_rdata(rt_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  // exc = {addr, overflow, syscall, break, invalid}; cp0 = {eret, mfc0, mtc0}
  typedef struct {
    logic        rst, stall, flush, valid, branch;
    logic [4:0]  exc;
    logic [2:0]  cp0;
    logic [4:0]  ca;
    logic [31:0] pc, rt;
    logic [13:0] e_et;
    logic [31:0] e_pc, e_rt;
    logic        e_mv;
  } vec_t;

  typedef struct {
    logic [13:0] et;
    logic [31:0] pc, rt;
    logic        mv;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic r, s, f, v, b, input logic [4:0] exc, input logic [2:0] cp0,
                              input logic [4:0] ca, input logic [31:0] pc, rt, input logic [13:0] eet,
                              input logic [31:0] epc, ert, input logic emv);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.valid = v; x.branch = b;
    x.exc = exc; x.cp0 = cp0; x.ca = ca; x.pc = pc; x.rt = rt;
    x.e_et = eet; x.e_pc = epc; x.e_rt = ert; x.e_mv = emv;
    return x;
  endfunction

  task automatic check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (excepttype !== e.et || current_pc !== e.pc || rt_rdata !== e.rt || mem_valid !== e.mv) begin
      n_err++;
      $display("FAIL %s: got et=%h pc=%h rt=%h mv=%b, expected et=%h pc=%h rt=%h mv=%b",
               name, excepttype, current_pc, rt_rdata, mem_valid, e.et, e.pc, e.rt, e.mv);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    exp_t e;
    rst = v.rst; stall = v.stall; flush = v.flush; ex_valid = v.valid; ex_is_branch = v.branch;
    {ex_addr_err, ex_overflow, ex_syscall, ex_break, ex_invalid} = v.exc;
    {ex_eret, ex_mfc0, ex_mtc0} = v.cp0;
    ex_cp0_addr = v.ca; ex_pc = v.pc; ex_rt_rdata = v.rt;
    e.et = v.e_et; e.pc = v.e_pc; e.rt = v.e_rt; e.mv = v.e_mv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic rand_reset(input string name);
    logic [31:0] rpc, rrt;
    logic [4:0]  rexc, rca;
    logic [2:0]  rcp;
    rpc  = $urandom; rrt = $urandom;
    rexc = 5'($urandom); rca = 5'($urandom); rcp = 3'($urandom);
    apply(mk(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), rexc, rcp, rca, rpc, rrt,
             14'h0000, PCR, 32'h0, 1'b0), name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    logic [31:0] r;

    // Single-cycle vectors with the tracker idle (no branches).
    tbl[0]  = mk(0,0,0,1,0, 5'b11100, 3'b100, 5'd0,  32'h200, 32'h11, 14'h0080, 32'h200, 32'h11, 1);
    tbl[1]  = mk(0,0,0,1,0, 5'b01000, 3'b000, 5'd0,  32'h204, 32'h12, 14'h0040, 32'h204, 32'h12, 1);
    tbl[2]  = mk(0,0,0,1,0, 5'b00000, 3'b010, 5'd12, 32'h208, 32'h13, 14'h1802, 32'h208, 32'h13, 1);
    tbl[3]  = mk(0,0,0,1,0, 5'b00100, 3'b010, 5'd12, 32'h20c, 32'h14, 14'h0020, 32'h20c, 32'h14, 1);
    tbl[4]  = mk(0,0,0,1,0, 5'b00111, 3'b000, 5'd0,  32'h210, 32'h15, 14'h0008, 32'h210, 32'h15, 1);
    tbl[5]  = mk(0,0,0,1,0, 5'b00110, 3'b000, 5'd0,  32'h214, 32'h16, 14'h0020, 32'h214, 32'h16, 1);
    tbl[6]  = mk(0,0,0,1,0, 5'b01010, 3'b000, 5'd0,  32'h218, 32'h17, 14'h0010, 32'h218, 32'h17, 1);
    tbl[7]  = mk(0,0,0,1,0, 5'b00000, 3'b100, 5'd7,  32'h21c, 32'h18, 14'h0004, 32'h21c, 32'h18, 1);
    tbl[8]  = mk(0,0,0,1,0, 5'b00000, 3'b001, 5'd31, 32'h220, 32'h19, 14'h3e01, 32'h220, 32'h19, 1);
    tbl[9]  = mk(0,0,0,0,0, 5'b00100, 3'b010, 5'd9,  32'h300, 32'h1a, 14'h0000, 32'h300, 32'h1a, 0);
    tbl[10] = mk(0,0,0,1,0, 5'b00000, 3'b000, 5'd9,  32'h304, 32'h1b, 14'h0000, 32'h304, 32'h1b, 1);
    tbl[11] = mk(0,0,0,1,0, 5'b10000, 3'b010, 5'd3,  32'h308, 32'h1c, 14'h0080, 32'h308, 32'h1c, 1);

    rand_reset("reset0");
    rand_reset("reset1");

    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Delay slot across a bubble; the following instruction is not in a slot.
    apply(mk(0,0,0,1,1, 5'b00000, 3'b000, 5'd0, 32'h100, 32'h21, 14'h0000, 32'h100, 32'h21, 1), "ds_branch");
    apply(mk(0,0,0,0,0, 5'b00000, 3'b000, 5'd0, 32'h104, 32'h22, 14'h0000, 32'h104, 32'h22, 0), "ds_bubble");
    apply(mk(0,0,0,1,0, 5'b00100, 3'b000, 5'd0, 32'h104, 32'h23, 14'h0120, 32'h104, 32'h23, 1), "ds_syscall");
    apply(mk(0,0,0,1,0, 5'b00000, 3'b000, 5'd0, 32'h108, 32'h24, 14'h0000, 32'h108, 32'h24, 1), "ds_after");

    // Branch in a delay slot re-arms the tracker.
    apply(mk(0,0,0,1,1, 5'b00000, 3'b000, 5'd0, 32'h110, 32'h25, 14'h0000, 32'h110, 32'h25, 1), "bb_first");
    apply(mk(0,0,0,1,1, 5'b00000, 3'b000, 5'd0, 32'h114, 32'h26, 14'h0100, 32'h114, 32'h26, 1), "bb_second");
    apply(mk(0,0,0,1,0, 5'b00000, 3'b001, 5'd2, 32'h118, 32'h27, 14'h0501, 32'h118, 32'h27, 1), "bb_slot_mtc0");

    // Flush with stall while PENDING: squashed, tracker cleared, PC/rt kept.
    apply(mk(0,0,0,1,1, 5'b00000, 3'b000, 5'd0, 32'h400, 32'haaaa, 14'h0000, 32'h400, 32'haaaa, 1), "fl_branch");
    apply(mk(0,1,1,1,0, 5'b00100, 3'b000, 5'd0, 32'h404, 32'hbbbb, 14'h0000, 32'h400, 32'haaaa, 0), "fl_squash");
    apply(mk(0,0,0,1,0, 5'b00100, 3'b000, 5'd0, 32'h404, 32'hcccc, 14'h0020, 32'h404, 32'hcccc, 1), "fl_next");

    // Stall hold on mtc0 with changing EX inputs.
    apply(mk(0,0,0,1,0, 5'b00000, 3'b001, 5'd14, 32'h500, 32'hdeadbeef, 14'h1c01, 32'h500, 32'hdeadbeef, 1), "st_load");
    for (int i = 0; i < 3; i++) begin
      r = $urandom;
      apply(mk(0,1,0,1,1, 5'(r), 3'(r >> 5), 5'(r >> 8), r, ~r, 14'h1c01, 32'h500, 32'hdeadbeef, 1),
            $sformatf("st_hold%0d", i));
    end
    apply(mk(0,0,0,1,0, 5'b00000, 3'b000, 5'd0, 32'h504, 32'h31, 14'h0000, 32'h504, 32'h31, 1), "st_release");

    // Tracker frozen while stalled in PENDING.
    apply(mk(0,0,0,1,1, 5'b00000, 3'b000, 5'd0, 32'h700, 32'h41, 14'h0000, 32'h700, 32'h41, 1), "sp_branch");
    apply(mk(0,1,0,1,0, 5'b00000, 3'b000, 5'd0, 32'h704, 32'h42, 14'h0000, 32'h700, 32'h41, 1), "sp_stall0");
    apply(mk(0,1,0,0,0, 5'b00000, 3'b000, 5'd0, 32'h708, 32'h43, 14'h0000, 32'h700, 32'h41, 1), "sp_stall1");
    apply(mk(0,0,0,1,0, 5'b00010, 3'b000, 5'd0, 32'h704, 32'h44, 14'h0110, 32'h704, 32'h44, 1), "sp_slot_break");

    // Reset while PENDING clears everything including the tracker.
    apply(mk(0,0,0,1,1, 5'b00000, 3'b000, 5'd0, 32'h600, 32'h51, 14'h0000, 32'h600, 32'h51, 1), "rp_branch");
    apply(mk(1,1,0,1,0, 5'b00100, 3'b000, 5'd0, 32'h604, 32'h52, 14'h0000, PCR, 32'h0, 0), "rp_reset");
    apply(mk(0,0,0,1,0, 5'b00100, 3'b000, 5'd0, 32'h604, 32'h53, 14'h0020, 32'h604, 32'h53, 1), "rp_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
